// File: rtl/vga_pkg.sv
// vga_pkg: shared 640x480@60 raster constants for the timing
// generator and the pattern stages that consume its coordinates.
package vga_pkg;

  localparam int COORD_W = 10;
  localparam int RGB_W   = 6;

  localparam int H_RES  = 640;
  localparam int H_FP   = 16;
  localparam int H_SYNC = 96;
  localparam int H_BP   = 48;

  localparam int V_RES  = 480;
  localparam int V_FP   = 10;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 33;

  localparam logic H_POL = 1'b0;
  localparam logic V_POL = 1'b0;

  function automatic int axis_total(
    input int res,
    input int fp,
    input int sync,
    input int bp
  );
    return res + fp + sync + bp;
  endfunction

  localparam int H_TOTAL = axis_total(H_RES, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_RES, V_FP, V_SYNC, V_BP);

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (line or frame direction).
// Flags are registered from the next count so they align with it.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int   RES  = H_RES,
  parameter int   FP   = H_FP,
  parameter int   SYNC = H_SYNC,
  parameter int   BP   = H_BP,
  parameter logic POL  = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               advance,
  output logic [COORD_W-1:0] count,
  output logic               active,
  output logic               sync,
  output logic               wrap
);

  localparam int TOTAL = axis_total(RES, FP, SYNC, BP);

  localparam logic [COORD_W-1:0] LAST  = COORD_W'(TOTAL - 1);
  localparam logic [COORD_W-1:0] ACT_N = COORD_W'(RES);
  localparam logic [COORD_W-1:0] S_BEG = COORD_W'(RES + FP);
  localparam logic [COORD_W-1:0] S_END = COORD_W'(RES + FP + SYNC - 1);

  logic [COORD_W-1:0] count_q, count_d;
  logic               active_q, active_d;
  logic               sync_q, sync_d;
  logic               wrap_d;

  // Next count and the flags that describe it.
  always_comb begin
    wrap_d   = advance && (count_q == LAST);
    count_d  = count_q;
    if (advance) begin
      count_d = wrap_d ? '0 : count_q + 1'b1;
    end
    active_d = (count_d < ACT_N);
    sync_d   = ((count_d >= S_BEG) && (count_d <= S_END)) ? POL : ~POL;
  end

  // Reset parks on the last position so the first edge wraps to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q  <= LAST;
      active_q <= 1'b0;
      sync_q   <= ~POL;
    end else begin
      count_q  <= count_d;
      active_q <= active_d;
      sync_q   <= sync_d;
    end
  end

  assign count  = count_q;
  assign active = active_q;
  assign sync   = sync_q;
  assign wrap   = wrap_d;

endmodule

// File: rtl/vga_timing.sv
// vga_timing: free-running raster timing generator.
// Macro VGA_SYNC_DELAY_EN adds one register stage on hsync/vsync.
module vga_timing
  import vga_pkg::*;
#(
  parameter int   H_RES  = vga_pkg::H_RES,
  parameter int   H_FP   = vga_pkg::H_FP,
  parameter int   H_SYNC = vga_pkg::H_SYNC,
  parameter int   H_BP   = vga_pkg::H_BP,
  parameter int   V_RES  = vga_pkg::V_RES,
  parameter int   V_FP   = vga_pkg::V_FP,
  parameter int   V_SYNC = vga_pkg::V_SYNC,
  parameter int   V_BP   = vga_pkg::V_BP,
  parameter logic H_POL  = vga_pkg::H_POL,
  parameter logic V_POL  = vga_pkg::V_POL
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [COORD_W-1:0] sx,
  output logic [COORD_W-1:0] sy,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic               line_start,
  output logic               frame_start
);

  logic h_active, h_sync, h_wrap;
  logic v_active, v_sync, v_wrap;
  logic line_start_q, frame_start_q;

  vga_axis_counter #(
    .RES (H_RES),
    .FP  (H_FP),
    .SYNC(H_SYNC),
    .BP  (H_BP),
    .POL (H_POL)
  ) u_h (
    .clk    (clk),
    .rst_n  (rst_n),
    .advance(1'b1),
    .count  (sx),
    .active (h_active),
    .sync   (h_sync),
    .wrap   (h_wrap)
  );

  vga_axis_counter #(
    .RES (V_RES),
    .FP  (V_FP),
    .SYNC(V_SYNC),
    .BP  (V_BP),
    .POL (V_POL)
  ) u_v (
    .clk    (clk),
    .rst_n  (rst_n),
    .advance(h_wrap),
    .count  (sy),
    .active (v_active),
    .sync   (v_sync),
    .wrap   (v_wrap)
  );

  // Strobes mark the edge on which the counters wrap to 0.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= h_wrap;
      frame_start_q <= h_wrap & v_wrap;
    end
  end

  assign de          = h_active & v_active;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_SYNC_DELAY_EN
  logic hsync_q, vsync_q;

  // Syncs lag one cycle to line up with registered pixel data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hsync_q <= ~H_POL;
      vsync_q <= ~V_POL;
    end else begin
      hsync_q <= h_sync;
      vsync_q <= v_sync;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
`else
  assign hsync = h_sync;
  assign vsync = v_sync;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: directed checks on a default 640x480 instance and
// a small active-high instance used for whole-frame behaviour.
module tb_vga_timing;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [COORD_W-1:0] sx_b, sy_b, sx_s, sy_s;
  logic de_b, hs_b, vs_b, ls_b, fs_b;
  logic de_s, hs_s, vs_s, ls_s, fs_s;

  vga_timing u_big (
    .clk        (clk),
    .rst_n      (rst_n),
    .sx         (sx_b),
    .sy         (sy_b),
    .de         (de_b),
    .hsync      (hs_b),
    .vsync      (vs_b),
    .line_start (ls_b),
    .frame_start(fs_b)
  );

  vga_timing #(
    .H_RES(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_RES(6),  .V_FP(2), .V_SYNC(2), .V_BP(3),
    .H_POL(1'b1), .V_POL(1'b1)
  ) u_small (
    .clk        (clk),
    .rst_n      (rst_n),
    .sx         (sx_s),
    .sy         (sy_s),
    .de         (de_s),
    .hsync      (hs_s),
    .vsync      (vs_s),
    .line_start (ls_s),
    .frame_start(fs_s)
  );

  typedef struct {
    int cyc;
    bit sel;
    int sx;
    int sy;
    bit de;
    bit hs;
    bit vs;
    bit ls;
    bit fs;
    bit hs_d;
    bit vs_d;
  } vec_t;

  vec_t tbl[$];
  int n_chk = 0;
  int n_fail = 0;
  int cur = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cur++;
  endtask

  task automatic chk_big_reset(input string tag);
    chk({tag, " sx"}, int'(sx_b), 799);
    chk({tag, " sy"}, int'(sy_b), 524);
    chk({tag, " de"}, int'(de_b), 0);
    chk({tag, " hsync"}, int'(hs_b), 1);
    chk({tag, " vsync"}, int'(vs_b), 1);
    chk({tag, " ls"}, int'(ls_b), 0);
    chk({tag, " fs"}, int'(fs_b), 0);
    chk({tag, " small sx"}, int'(sx_s), 31);
    chk({tag, " small sy"}, int'(sy_s), 12);
    chk({tag, " small hsync"}, int'(hs_s), 0);
    chk({tag, " small vsync"}, int'(vs_s), 0);
  endtask

  task automatic chk_origin(input string tag);
    chk({tag, " sx"}, int'(sx_b), 0);
    chk({tag, " sy"}, int'(sy_b), 0);
    chk({tag, " de"}, int'(de_b), 1);
    chk({tag, " fs"}, int'(fs_b), 1);
    chk({tag, " ls"}, int'(ls_b), 1);
    chk({tag, " hsync"}, int'(hs_b), 1);
    chk({tag, " small sx"}, int'(sx_s), 0);
    chk({tag, " small fs"}, int'(fs_s), 1);
  endtask

  initial begin
    int de_cnt, hs_cnt, ls_cnt, n, vs_cnt, k;
    bit g_de, g_hs, g_vs, g_ls, g_fs, e_hs, e_vs;
    int g_sx, g_sy;

    // cyc sel sx sy de hs vs ls fs hs_d vs_d
    tbl.push_back('{15,  1, 15, 0, 1, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{16,  1, 16, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{20,  1, 20, 0, 0, 1, 0, 0, 0, 0, 0});
    tbl.push_back('{21,  1, 21, 0, 0, 1, 0, 0, 0, 1, 0});
    tbl.push_back('{25,  1, 25, 0, 0, 1, 0, 0, 0, 1, 0});
    tbl.push_back('{26,  1, 26, 0, 0, 0, 0, 0, 0, 1, 0});
    tbl.push_back('{27,  1, 27, 0, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{160, 1, 0,  5, 1, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{192, 1, 0,  6, 0, 0, 0, 1, 0, 0, 0});
    tbl.push_back('{256, 1, 0,  8, 0, 0, 1, 1, 0, 0, 0});
    tbl.push_back('{257, 1, 1,  8, 0, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{320, 1, 0, 10, 0, 0, 0, 1, 0, 0, 1});
    tbl.push_back('{415, 1, 31, 12, 0, 0, 0, 0, 0, 0, 0});
    tbl.push_back('{416, 1, 0,  0, 1, 0, 0, 1, 1, 0, 0});
    tbl.push_back('{639, 0, 639, 0, 1, 1, 1, 0, 0, 1, 1});
    tbl.push_back('{640, 0, 640, 0, 0, 1, 1, 0, 0, 1, 1});
    tbl.push_back('{656, 0, 656, 0, 0, 0, 1, 0, 0, 1, 1});
    tbl.push_back('{657, 0, 657, 0, 0, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{751, 0, 751, 0, 0, 0, 1, 0, 0, 0, 1});
    tbl.push_back('{752, 0, 752, 0, 0, 1, 1, 0, 0, 0, 1});
    tbl.push_back('{753, 0, 753, 0, 0, 1, 1, 0, 0, 1, 1});
    tbl.push_back('{799, 0, 799, 0, 0, 1, 1, 0, 0, 1, 1});
    tbl.push_back('{800, 0, 0,   1, 1, 1, 1, 1, 0, 1, 1});
    tbl.push_back('{801, 0, 1,   1, 1, 1, 1, 0, 0, 1, 1});
    tbl.push_back('{1600, 0, 0,  2, 1, 1, 1, 1, 0, 1, 1});

    // Reset held for five cycles.
    repeat (5) step();
    chk_big_reset("reset");

    rst_n = 1'b1;
    step();
    cur = 0;
    chk_origin("release");

    // One full line of the default instance.
    de_cnt = 0;
    hs_cnt = 0;
    ls_cnt = 0;
    while (cur < 800) begin
      if (de_b) de_cnt++;
      if (!hs_b) hs_cnt++;
      if (ls_b) ls_cnt++;
      step();
    end
    chk("line de count", de_cnt, 640);
    chk("line hsync low count", hs_cnt, 96);
    chk("line ls count", ls_cnt, 1);
    chk("line wrap sx", int'(sx_b), 0);
    chk("line wrap sy", int'(sy_b), 1);

    // Mid-frame one-cycle reset.
    while (cur < 1100) step();
    chk("pre-reset sx", int'(sx_b), 300);
    chk("pre-reset sy", int'(sy_b), 1);
    rst_n = 1'b0;
    step();
    chk_big_reset("midreset");
    rst_n = 1'b1;
    step();
    cur = 0;
    chk_origin("restart");

    // Directed vectors, ascending in cycle order.
    foreach (tbl[i]) begin
      while (cur < tbl[i].cyc) step();
      if (tbl[i].sel) begin
        g_sx = int'(sx_s); g_sy = int'(sy_s);
        g_de = de_s; g_hs = hs_s; g_vs = vs_s;
        g_ls = ls_s; g_fs = fs_s;
      end else begin
        g_sx = int'(sx_b); g_sy = int'(sy_b);
        g_de = de_b; g_hs = hs_b; g_vs = vs_b;
        g_ls = ls_b; g_fs = fs_b;
      end
`ifdef VGA_SYNC_DELAY_EN
      e_hs = tbl[i].hs_d;
      e_vs = tbl[i].vs_d;
`else
      e_hs = tbl[i].hs;
      e_vs = tbl[i].vs;
`endif
      chk($sformatf("v%0d sx", i), g_sx, tbl[i].sx);
      chk($sformatf("v%0d sy", i), g_sy, tbl[i].sy);
      chk($sformatf("v%0d de", i), int'(g_de), int'(tbl[i].de));
      chk($sformatf("v%0d hsync", i), int'(g_hs), int'(e_hs));
      chk($sformatf("v%0d vsync", i), int'(g_vs), int'(e_vs));
      chk($sformatf("v%0d ls", i), int'(g_ls), int'(tbl[i].ls));
      chk($sformatf("v%0d fs", i), int'(g_fs), int'(tbl[i].fs));
    end

    // Two whole frames of the small instance.
    k = 0;
    while (!fs_s && k < 500) begin
      step();
      k++;
    end
    chk("small fs found", int'(fs_s), 1);
    for (int f = 0; f < 2; f++) begin
      n = 0;
      vs_cnt = 0;
      de_cnt = 0;
      do begin
        if (vs_s) vs_cnt++;
        if (de_s) de_cnt++;
        step();
        n++;
      end while (!fs_s && n < 1000);
      chk($sformatf("frame%0d length", f), n, 416);
      chk($sformatf("frame%0d vsync count", f), vs_cnt, 64);
      chk($sformatf("frame%0d de count", f), de_cnt, 96);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
